// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART packet controller.
// Contents:
//   SOF_BYTE   - start-of-frame marker that opens every packet
//   state_t    - packet FSM states
//   err_code_t - codes reported alongside the err pulse
package uart_cmd_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        HUNT,
        CMD,
        LEN,
        PAYLOAD,
        CHECK,
        DRAIN
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_FRAME,
        ERR_LEN,
        ERR_CHK,
        ERR_TIMEOUT,
        ERR_OVERRUN
    } err_code_t;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bus bundle between the UART receiver / hashing datapath and uart_cmd_ctrl.
// Signals:
//   rx_data, rx_valid, rx_framing_err  byte stream from the UART receiver
//   out_cmd, out_len, out_data, out_valid, out_ready, out_last  payload stream
//   err, err_code                      1-cycle discard report
//   busy                               controller is not hunting for SOF
//   state                              FSM state, for debug and checkers
//   stat_clr, stat_good, stat_bad      only with UART_CMD_CTRL_STATS_EN defined
// Handshake: a payload byte moves on a rising clk edge where out_valid && out_ready;
// while out_valid is high and out_ready low, out_data/out_last/out_cmd/out_len hold.
// Modports: slave is the controller side, master is the surrounding system side.
interface uart_cmd_ctrl_if;
    import uart_cmd_pkg::*;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_framing_err;
    logic [7:0] out_cmd;
    logic [7:0] out_len;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       err;
    err_code_t  err_code;
    logic       busy;
    state_t     state;
`ifdef UART_CMD_CTRL_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_good;
    logic [15:0] stat_bad;
`endif

    modport slave (
        input  rx_data, rx_valid, rx_framing_err, out_ready,
`ifdef UART_CMD_CTRL_STATS_EN
        input  stat_clr,
        output stat_good, stat_bad,
`endif
        output out_cmd, out_len, out_data, out_valid, out_last, err, err_code, busy, state
    );

    modport master (
        output rx_data, rx_valid, rx_framing_err, out_ready,
`ifdef UART_CMD_CTRL_STATS_EN
        output stat_clr,
        input  stat_good, stat_bad,
`endif
        input  out_cmd, out_len, out_data, out_valid, out_last, err, err_code, busy, state
    );

endinterface

// File: rtl/uart_pkt_buf.sv
// Payload byte buffer: DEPTH x 8, one synchronous write port, one asynchronous read port.
// Ports:
//   clk          clock
//   we, waddr, wdata   write port (payload capture)
//   raddr, rdata       read port (drain), combinational
module uart_pkt_buf #(
    parameter int DEPTH = 80,
    parameter int PW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [PW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Packet controller behind an 8-N-1 UART receiver.
// Hunts for SOF (0xA5), parses CMD LEN P[0..LEN-1] CHK with CHK = XOR(CMD, LEN, P[*]),
// buffers the payload and streams it out only once the checksum matches.
// Parameters: MAX_LEN (1..255 payload bytes), TIMEOUT_CYC (inter-byte timeout, 0 = off).
// Ports: clk, rst (synchronous, active-high), bus (uart_cmd_ctrl_if.slave).
// Optional: define UART_CMD_CTRL_STATS_EN for saturating good/bad packet counters.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN     = 80,
    parameter int TIMEOUT_CYC = 500_000
) (
    input  logic           clk,
    input  logic           rst,
    uart_cmd_ctrl_if.slave bus
);

    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT_CYC);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    state_t          state, state_n;
    logic [7:0]      cmd, cmd_n, len, len_n, chk, chk_n;
    logic [PW-1:0]   wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
    logic [TW-1:0]   to_cnt, to_cnt_n;
    logic            err_q, err_n;
    err_code_t       code_q, code_n;
    logic            buf_we, good_pkt, mid, last, drain_hs, to_fire;
    logic [7:0]      buf_rdata;

    uart_pkt_buf #(.DEPTH(MAX_LEN), .PW(PW)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_ptr),
        .wdata (bus.rx_data),
        .raddr (rd_ptr),
        .rdata (buf_rdata)
    );

    assign mid      = (state == CMD) || (state == LEN) || (state == PAYLOAD) || (state == CHECK);
    assign last     = (8'(rd_ptr) == len - 8'd1);
    assign drain_hs = (state == DRAIN) && bus.out_ready;
    // A byte arriving in the same cycle beats the timeout.
    assign to_fire  = (TIMEOUT_CYC != 0) && mid && (to_cnt == TO_LIM) && !bus.rx_valid;

    // Counter only runs mid-packet, clears on any byte, and saturates at the limit.
    always_comb begin
        to_cnt_n = to_cnt;
        if (bus.rx_valid || !mid) begin
            to_cnt_n = '0;
        end else if (to_cnt != TO_LIM) begin
            to_cnt_n = to_cnt + TW'(1);
        end
    end

    always_comb begin
        state_n  = state;
        cmd_n    = cmd;
        len_n    = len;
        chk_n    = chk;
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        err_n    = 1'b0;
        code_n   = ERR_NONE;
        buf_we   = 1'b0;
        good_pkt = 1'b0;
        if (bus.rx_valid) begin
            if (bus.rx_framing_err) begin
                // A bad byte during DRAIN is just another unwanted byte: overrun.
                err_n = 1'b1;
                if (state == DRAIN) begin
                    code_n = ERR_OVERRUN;
                end else begin
                    code_n  = ERR_FRAME;
                    state_n = HUNT;
                end
            end else begin
                case (state)
                    HUNT: begin
                        if (bus.rx_data == SOF_BYTE) state_n = CMD;
                    end
                    CMD: begin
                        cmd_n   = bus.rx_data;
                        chk_n   = bus.rx_data;
                        state_n = LEN;
                    end
                    LEN: begin
                        if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
                            err_n   = 1'b1;
                            code_n  = ERR_LEN;
                            state_n = HUNT;
                        end else begin
                            len_n    = bus.rx_data;
                            chk_n    = chk ^ bus.rx_data;
                            wr_ptr_n = '0;
                            state_n  = PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        buf_we   = 1'b1;
                        chk_n    = chk ^ bus.rx_data;
                        wr_ptr_n = wr_ptr + PW'(1);
                        if (8'(wr_ptr) == len - 8'd1) state_n = CHECK;
                    end
                    CHECK: begin
                        if (bus.rx_data == chk) begin
                            good_pkt = 1'b1;
                            rd_ptr_n = '0;
                            state_n  = DRAIN;
                        end else begin
                            err_n   = 1'b1;
                            code_n  = ERR_CHK;
                            state_n = HUNT;
                        end
                    end
                    DRAIN: begin
                        err_n  = 1'b1;
                        code_n = ERR_OVERRUN;
                    end
                    default: state_n = HUNT;
                endcase
            end
        end else if (to_fire) begin
            err_n   = 1'b1;
            code_n  = ERR_TIMEOUT;
            state_n = HUNT;
        end
        // Drain proceeds regardless of any overrun byte in the same cycle.
        if (drain_hs) begin
            rd_ptr_n = rd_ptr + PW'(1);
            if (last) state_n = HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= HUNT;
            cmd    <= '0;
            len    <= '0;
            chk    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            to_cnt <= '0;
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
        end else begin
            state  <= state_n;
            cmd    <= cmd_n;
            len    <= len_n;
            chk    <= chk_n;
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            to_cnt <= to_cnt_n;
            err_q  <= err_n;
            code_q <= code_n;
        end
    end

    assign bus.out_valid = (state == DRAIN);
    assign bus.out_data  = bus.out_valid ? buf_rdata : 8'd0;
    assign bus.out_last  = bus.out_valid && last;
    assign bus.out_cmd   = cmd;
    assign bus.out_len   = len;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;
    assign bus.busy      = (state != HUNT);
    assign bus.state     = state;

`ifdef UART_CMD_CTRL_STATS_EN
    logic [15:0] stat_good_q, stat_bad_q;

    always_ff @(posedge clk) begin
        if (rst || bus.stat_clr) begin
            stat_good_q <= '0;
            stat_bad_q  <= '0;
        end else begin
            if (good_pkt && stat_good_q != 16'hFFFF) stat_good_q <= stat_good_q + 16'd1;
            if (err_n && stat_bad_q != 16'hFFFF)     stat_bad_q  <= stat_bad_q + 16'd1;
        end
    end

    assign bus.stat_good = stat_good_q;
    assign bus.stat_bad  = stat_bad_q;
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl (MAX_LEN = 80, TIMEOUT_CYC shortened to 40).
// Inputs change 1 time unit after a rising edge; a monitor samples on falling edges.
module tb_uart_cmd_ctrl;
    import uart_cmd_pkg::*;

    localparam int MAX_LEN = 80;
    localparam int TO      = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if bus();

    uart_cmd_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          err_seen = 0;
    err_code_t   last_code = ERR_NONE;
    logic [8:0]  got_q[$];
    logic [8:0]  exp_q[$];

    // Records {out_last, out_data} of every handshake and every err pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_last, bus.out_data});
            if (bus.err) begin
                err_seen++;
                last_code = bus.err_code;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic fe);
        bus.rx_data        = b;
        bus.rx_valid       = 1'b1;
        bus.rx_framing_err = fe;
        tick(1);
        bus.rx_valid       = 1'b0;
        bus.rx_framing_err = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        n_cmp++; if ({bus.out_valid, bus.out_last, bus.err, bus.busy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=0000", {bus.out_valid, bus.out_last, bus.err, bus.busy});
        end
        n_cmp++; if ({bus.out_cmd, bus.out_len, bus.out_data} !== 24'h0) begin
            n_fail++; $display("FAIL reset_bytes got=%h exp=000000", {bus.out_cmd, bus.out_len, bus.out_data});
        end
        n_cmp++; if (bus.err_code !== ERR_NONE || bus.state !== HUNT) begin
            n_fail++; $display("FAIL reset_state code=%0d state=%0d exp=0/0", bus.err_code, bus.state);
        end
        rst = 1'b0;
        tick(1);
    endtask

    // A5 01 03 10 20 30 02 : checksum 01^03^10^20^30 = 02.
    task automatic test_good_packet();
        bit ok;
        int e0 = err_seen;
        bus.out_ready = 1'b1;
        send(8'hA5, 1'b0);
        n_cmp++; if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL good_busy got=%b exp=1", bus.busy);
        end
        send(8'h01, 1'b0); send(8'h03, 1'b0);
        send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0);
        send(8'h02, 1'b0);
        n_cmp++; if ({bus.out_valid, bus.out_last, bus.out_cmd, bus.out_len, bus.out_data} !== {2'b10, 24'h010310}) begin
            n_fail++; $display("FAIL good_first got=%h exp=%h",
                {bus.out_valid, bus.out_last, bus.out_cmd, bus.out_len, bus.out_data}, {2'b10, 24'h010310});
        end
        wait_idle(20, ok);
        n_cmp++; if (!ok) begin
            n_fail++; $display("FAIL good_idle got=busy exp=idle within 20");
        end
        exp_q = '{9'h010, 9'h020, 9'h130};
        n_cmp++; if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL good_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL good_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        n_cmp++; if (err_seen != e0) begin
            n_fail++; $display("FAIL good_noerr got=%0d exp=%0d", err_seen, e0);
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_bad_checksum();
        bit ok;
        bus.out_ready = 1'b1;
        send(8'hA5, 1'b0); send(8'h01, 1'b0); send(8'h03, 1'b0);
        send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0);
        send(8'h00, 1'b0);
        n_cmp++; if ({bus.err, bus.err_code} !== {1'b1, 3'd3}) begin
            n_fail++; $display("FAIL chk_err got=%b/%0d exp=1/3", bus.err, bus.err_code);
        end
        n_cmp++; if ({bus.out_valid, bus.busy} !== 2'b00) begin
            n_fail++; $display("FAIL chk_idle got=%b exp=00", {bus.out_valid, bus.busy});
        end
        tick(1);
        n_cmp++; if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL chk_pulse got=%b exp=0", bus.err);
        end
        // A5 07 01 42 44 : checksum 07^01^42 = 44.
        send(8'hA5, 1'b0); send(8'h07, 1'b0); send(8'h01, 1'b0);
        send(8'h42, 1'b0); send(8'h44, 1'b0);
        wait_idle(20, ok);
        n_cmp++; if (!ok || got_q.size() != 1) begin
            n_fail++; $display("FAIL chk_next_count got=%0d exp=1", got_q.size());
        end else begin
            n_cmp++; if (got_q[0] !== 9'h142) begin
                n_fail++; $display("FAIL chk_next_byte got=%h exp=142", got_q[0]);
            end
        end
        got_q.delete();
    endtask

    task automatic test_bad_len();
        int e0 = err_seen;
        send(8'h00, 1'b0); send(8'hFF, 1'b0);
        tick(1);
        n_cmp++; if (err_seen != e0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL len_stray got=%0d/%b exp=%0d/0", err_seen, bus.busy, e0);
        end
        send(8'hA5, 1'b0); send(8'h02, 1'b0); send(8'h00, 1'b0);
        n_cmp++; if ({bus.err, bus.err_code, bus.busy} !== {1'b1, 3'd2, 1'b0}) begin
            n_fail++; $display("FAIL len_zero got=%b/%0d/%b exp=1/2/0", bus.err, bus.err_code, bus.busy);
        end
        send(8'hA5, 1'b0); send(8'h02, 1'b0); send(8'h51, 1'b0);
        n_cmp++; if ({bus.err, bus.err_code, bus.busy} !== {1'b1, 3'd2, 1'b0}) begin
            n_fail++; $display("FAIL len_81 got=%b/%0d/%b exp=1/2/0", bus.err, bus.err_code, bus.busy);
        end
        tick(1);
        n_cmp++; if (err_seen != e0 + 2) begin
            n_fail++; $display("FAIL len_errs got=%0d exp=%0d", err_seen, e0 + 2);
        end
    endtask

    task automatic test_timeout();
        int e0;
        send(8'hA5, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'hAA, 1'b0);
        e0 = err_seen;
        tick(TO - 5);
        n_cmp++; if (bus.busy !== 1'b1 || err_seen != e0) begin
            n_fail++; $display("FAIL to_early got=%b/%0d exp=1/%0d", bus.busy, err_seen, e0);
        end
        tick(10);
        n_cmp++; if (bus.busy !== 1'b0 || err_seen != e0 + 1 || last_code !== ERR_TIMEOUT) begin
            n_fail++; $display("FAIL to_fire got=%b/%0d/%0d exp=0/%0d/4", bus.busy, err_seen, last_code, e0 + 1);
        end
        tick(TO + 10);
        n_cmp++; if (err_seen != e0 + 1) begin
            n_fail++; $display("FAIL to_once got=%0d exp=%0d", err_seen, e0 + 1);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        bus.out_ready = 1'b0;
        send(8'hA5, 1'b0); send(8'h01, 1'b0); send(8'h03, 1'b0);
        send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0);
        send(8'h02, 1'b0);
        tick(3);
        send(8'h55, 1'b0);
        n_cmp++; if ({bus.err, bus.err_code, bus.out_valid, bus.out_data} !== {1'b1, 3'd5, 1'b1, 8'h10}) begin
            n_fail++; $display("FAIL ovr_byte got=%b/%0d/%b/%h exp=1/5/1/10", bus.err, bus.err_code, bus.out_valid, bus.out_data);
        end
        send(8'h66, 1'b1);
        n_cmp++; if ({bus.err, bus.err_code} !== {1'b1, 3'd5}) begin
            n_fail++; $display("FAIL ovr_frame got=%b/%0d exp=1/5", bus.err, bus.err_code);
        end
        tick(14);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10 || got_q.size() != 0) begin
            n_fail++; $display("FAIL ovr_hold got=%b/%h/%0d exp=1/10/0", bus.out_valid, bus.out_data, got_q.size());
        end
        bus.out_ready = 1'b1;
        wait_idle(20, ok);
        exp_q = '{9'h010, 9'h020, 9'h130};
        n_cmp++; if (!ok || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL ovr_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL ovr_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_framing();
        // LEN = 0x50 (80) is the largest length accepted.
        send(8'hA5, 1'b0); send(8'h03, 1'b0); send(8'h50, 1'b0);
        n_cmp++; if (bus.busy !== 1'b1 || bus.err !== 1'b0 || bus.state !== PAYLOAD) begin
            n_fail++; $display("FAIL frm_len80 got=%b/%b/%0d exp=1/0/3", bus.busy, bus.err, bus.state);
        end
        send(8'h11, 1'b1);
        n_cmp++; if ({bus.err, bus.err_code, bus.busy} !== {1'b1, 3'd1, 1'b0}) begin
            n_fail++; $display("FAIL frm_payload got=%b/%0d/%b exp=1/1/0", bus.err, bus.err_code, bus.busy);
        end
        send(8'h22, 1'b1);
        n_cmp++; if ({bus.err, bus.err_code, bus.busy} !== {1'b1, 3'd1, 1'b0}) begin
            n_fail++; $display("FAIL frm_hunt got=%b/%0d/%b exp=1/1/0", bus.err, bus.err_code, bus.busy);
        end
    endtask

    task automatic test_rst_drain();
        bit ok;
        bus.out_ready = 1'b0;
        send(8'hA5, 1'b0); send(8'h07, 1'b0); send(8'h01, 1'b0);
        send(8'h42, 1'b0); send(8'h44, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre got=%b exp=1", bus.out_valid);
        end
        rst = 1'b1;
        tick(1);
        n_cmp++; if ({bus.out_valid, bus.busy} !== 2'b00) begin
            n_fail++; $display("FAIL rst_drop got=%b exp=00", {bus.out_valid, bus.busy});
        end
        rst = 1'b0;
        tick(1);
        got_q.delete();
        bus.out_ready = 1'b1;
        send(8'hA5, 1'b0); send(8'h09, 1'b0); send(8'h02, 1'b0);
        send(8'h5A, 1'b0); send(8'h3C, 1'b0); send(8'h6D, 1'b0);  // 09^02^5A^3C = 6D
        wait_idle(20, ok);
        exp_q = '{9'h05A, 9'h13C};
        n_cmp++; if (!ok || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rst_after_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rst_after_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        bus.rx_data        = 8'h00;
        bus.rx_valid       = 1'b0;
        bus.rx_framing_err = 1'b0;
        bus.out_ready      = 1'b0;
`ifdef UART_CMD_CTRL_STATS_EN
        bus.stat_clr       = 1'b0;
`endif
        test_reset();
        test_good_packet();
        test_bad_checksum();
        test_bad_len();
        test_timeout();
        test_overrun();
        test_framing();
        test_rst_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
